frame_bank_arbiter: RTL and testbench

Ping-pong frame buffer controller that shares two 3-bit grayscale image RAM banks between the camera-side pixel writer and the VGA-side reader. The writer always fills one bank while the reader always scans the other. Banks swap only during VGA vertical blank, after a complete frame has been written, so the displayed 200x200 window never tears. The block sits between the camera capture path, the two frame RAMs and the VGA readout block.

---
 rtl/frame_bank_arbiter_if.sv | 39 +++
 rtl/frame_bank_arbiter.sv | 130 +++++++++++++
 tb/tb_frame_bank_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_bank_arbiter_if.sv
// Bus bundle between the ping-pong frame bank arbiter, the capture writer,
// the VGA reader and the two frame RAM banks.
interface frame_bank_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              wr_sof;
  logic              wr_req;
  logic [2:0]        wr_data;
  logic              wr_ready;
  logic              rd_vblank;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_data;
  logic [ADDR_W-1:0] b0_addr;
  logic [ADDR_W-1:0] b1_addr;
  logic [2:0]        b0_wdata;
  logic [2:0]        b1_wdata;
  logic              b0_wren;
  logic              b1_wren;
  logic              b0_rden;
  logic              b1_rden;
  logic [2:0]        b0_rdata;
  logic [2:0]        b1_rdata;
  logic              rd_bank;
  logic              frame_valid;
  logic [7:0]        drop_cnt;

  modport slave (
    input  wr_sof, wr_req, wr_data, rd_vblank, rd_en, rd_addr, b0_rdata, b1_rdata,
    output wr_ready, rd_data, b0_addr, b1_addr, b0_wdata, b1_wdata,
           b0_wren, b1_wren, b0_rden, b1_rden, rd_bank, frame_valid, drop_cnt
  );

  modport master (
    output wr_sof, wr_req, wr_data, rd_vblank, rd_en, rd_addr, b0_rdata, b1_rdata,
    input  wr_ready, rd_data, b0_addr, b1_addr, b0_wdata, b1_wdata,
           b0_wren, b1_wren, b0_rden, b1_rden, rd_bank, frame_valid, drop_cnt
  );
endinterface

// File: rtl/frame_bank_arbiter.sv
// Ping-pong frame buffer controller: writer fills one bank while the reader scans
// the other; banks swap in vertical blank. Define FRAME_BANK_DROP_CNT_EN for drop_cnt.
module frame_bank_arbiter #(
  parameter int FRAME_WORDS = 40000,
  parameter int ADDR_W      = 16
) (
  input logic                 vclk,
  input logic                 rst,
  frame_bank_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [2:0]        wr_data_q;
  logic              wr_en_q;
  logic              rd_bank_q;
  logic              frame_valid_q;
  logic              rd_sel_q;
  logic              rd_valid_q;

  assign bus.wr_ready    = (state_q == FILL);
  assign bus.rd_bank     = rd_bank_q;
  assign bus.frame_valid = frame_valid_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      waddr_q       <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_en_q       <= 1'b0;
      rd_bank_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      rd_sel_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      wr_en_q    <= 1'b0;
      rd_sel_q   <= rd_bank_q;
      rd_valid_q <= frame_valid_q;
      case (state_q)
        IDLE: begin
          if (bus.wr_sof) begin
            state_q <= FILL;
            waddr_q <= '0;
          end
        end
        FILL: begin
          // A start-of-frame pulse restarts the frame and wins over a coincident pixel.
          if (bus.wr_sof) begin
            waddr_q <= '0;
          end else if (bus.wr_req) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= waddr_q;
            wr_data_q <= bus.wr_data;
            if (waddr_q == LAST_ADDR) begin
              state_q <= DONE;
              waddr_q <= '0;
            end else begin
              waddr_q <= waddr_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.rd_vblank) begin
            rd_bank_q     <= ~rd_bank_q;
            frame_valid_q <= 1'b1;
            state_q       <= bus.wr_sof ? FILL : IDLE;
            waddr_q       <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FRAME_BANK_DROP_CNT_EN
  logic       sof_drop;
  logic [7:0] drop_cnt_q;

  // Swap-cycle start-of-frame pulses are consumed by the new frame, not dropped.
  assign sof_drop = bus.wr_sof &&
                    ((state_q == FILL) || ((state_q == DONE) && !bus.rd_vblank));

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (sof_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = '0;
`endif

  // NOTE: every output is given a default first so no path leaves a latch.
  always_comb begin
    bus.b0_addr  = wr_addr_q;
    bus.b0_wdata = wr_data_q;
    bus.b0_wren  = wr_en_q;
    bus.b0_rden  = 1'b0;
    bus.b1_addr  = wr_addr_q;
    bus.b1_wdata = wr_data_q;
    bus.b1_wren  = wr_en_q;
    bus.b1_rden  = 1'b0;
    if (rd_bank_q) begin
      bus.b1_addr  = bus.rd_addr;
      bus.b1_wdata = '0;
      bus.b1_wren  = 1'b0;
      bus.b1_rden  = bus.rd_en;
    end else begin
      bus.b0_addr  = bus.rd_addr;
      bus.b0_wdata = '0;
      bus.b0_wren  = 1'b0;
      bus.b0_rden  = bus.rd_en;
    end
  end

  // Select and blanking are delayed one cycle to line up with RAM read latency.
  assign bus.rd_data = !rd_valid_q ? 3'b000 : (rd_sel_q ? bus.b1_rdata : bus.b0_rdata);

endmodule

// File: tb/tb_frame_bank_arbiter.sv
// Randomized bench for frame_bank_arbiter: bench-side RAM banks plus a frame-level
// reference model of which bank holds which pixels and what the reader must see.
module tb_frame_bank_arbiter;
  localparam int FRAME_WORDS = 40000;
  localparam int ADDR_W      = 16;

  logic vclk = 1'b0;
  logic rst  = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 vclk = ~vclk;

  frame_bank_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  frame_bank_arbiter #(.FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W)) dut (
    .vclk (vclk),
    .rst  (rst),
    .bus  (bus)
  );

  // Two frame RAMs with one cycle read latency, seeded with nonzero junk.
  logic [2:0] ram [2][FRAME_WORDS];
  bit         seeded = 1'b0;
  always @(posedge vclk) begin
    if (!seeded) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < FRAME_WORDS; i++) ram[b][i] <= 3'($urandom_range(1, 7));
      seeded <= 1'b1;
    end else begin
      if (bus.b0_wren && int'(bus.b0_addr) < FRAME_WORDS) ram[0][bus.b0_addr] <= bus.b0_wdata;
      if (bus.b1_wren && int'(bus.b1_addr) < FRAME_WORDS) ram[1][bus.b1_addr] <= bus.b1_wdata;
      if (bus.b0_rden && int'(bus.b0_addr) < FRAME_WORDS) bus.b0_rdata <= ram[0][bus.b0_addr];
      if (bus.b1_rden && int'(bus.b1_addr) < FRAME_WORDS) bus.b1_rdata <= ram[1][bus.b1_addr];
    end
  end

  // Reference model: frame contents per bank plus what the reader should observe.
  bit       m_filling, m_full, m_rd_bank, m_valid, m_valid_d, m_wr_pend;
  int       m_count, m_drops, m_wr_addr;
  bit [2:0] m_wr_data, m_rd_word;
  bit [2:0] m_frame [2][FRAME_WORDS];

  function automatic int exp_drop();
`ifdef FRAME_BANK_DROP_CNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_filling = 0; m_full = 0; m_rd_bank = 0; m_valid = 0; m_valid_d = 0;
    m_wr_pend = 0; m_count = 0; m_drops = 0; m_rd_word = 0;
  endtask

  task automatic model_step();
    if (bus.rd_en && int'(bus.rd_addr) < FRAME_WORDS) m_rd_word = m_frame[m_rd_bank][bus.rd_addr];
    m_valid_d = m_valid;
    m_wr_pend = 0;
    if (m_full) begin
      if (bus.rd_vblank) begin
        m_rd_bank = !m_rd_bank; m_valid = 1; m_full = 0;
        m_filling = bus.wr_sof; m_count = 0;
      end else if (bus.wr_sof) begin
        m_drops = (m_drops < 255) ? m_drops + 1 : 255;
      end
    end else if (m_filling) begin
      if (bus.wr_sof) begin
        m_count = 0;
        m_drops = (m_drops < 255) ? m_drops + 1 : 255;
      end else if (bus.wr_req) begin
        m_frame[!m_rd_bank][m_count] = bus.wr_data;
        m_wr_pend = 1; m_wr_addr = m_count; m_wr_data = bus.wr_data;
        m_count++;
        if (m_count == FRAME_WORDS) begin m_full = 1; m_filling = 0; end
      end
    end else if (bus.wr_sof) begin
      m_filling = 1; m_count = 0;
    end
  endtask

  task automatic cycle();
    @(posedge vclk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit sof, input bit req, input bit vb);
    bus.wr_sof    = sof;
    bus.wr_req    = req;
    bus.wr_data   = 3'($urandom);
    bus.rd_vblank = vb;
    bus.rd_en     = 1'b1;
    bus.rd_addr   = ADDR_W'($urandom_range(0, FRAME_WORDS - 1));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(0, 0, 0);
    repeat (2) @(posedge vclk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [ADDR_W-1:0] wa;
    apply_reset();
    drive(0, 0, 0);
    @(negedge vclk);
    wa = bus.b1_addr;
    n_checks++; if (bus.wr_ready !== 1'b0) begin n_errors++; $display("FAIL reset_wr_ready got %0b want 0", bus.wr_ready); end
    n_checks++; if ({bus.rd_bank, bus.frame_valid} !== 2'b00) begin n_errors++; $display("FAIL reset_bank_valid got %b want 00", {bus.rd_bank, bus.frame_valid}); end
    n_checks++; if (bus.drop_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_drop got %0d want 0", bus.drop_cnt); end
    n_checks++; if ({bus.b0_wren, bus.b1_wren, bus.b1_wdata} !== 5'd0 || wa !== '0) begin n_errors++; $display("FAIL reset_write_port got wren=%b%b wdata=%0d addr=%0d want 0", bus.b0_wren, bus.b1_wren, bus.b1_wdata, wa); end
    n_checks++; if (bus.rd_data !== 3'd0) begin n_errors++; $display("FAIL reset_rd_data got %0d want 0", bus.rd_data); end
    n_checks++; if (bus.b0_addr !== bus.rd_addr || bus.b0_rden !== 1'b1 || bus.b1_rden !== 1'b0) begin n_errors++; $display("FAIL reset_read_route got addr=%0d rden=%b%b want addr=%0d rden=10", bus.b0_addr, bus.b0_rden, bus.b1_rden, bus.rd_addr); end
    cycle();
  endtask

  // Shared per-cycle observation of the write port, reader output and wr_ready.
  task automatic observe_cycle(input string tag);
    logic [1:0]        wren_exp;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_data, rd_exp;
    @(negedge vclk);
    wren_exp = m_wr_pend ? (m_rd_bank ? 2'b10 : 2'b01) : 2'b00;
    w_addr   = m_rd_bank ? bus.b0_addr  : bus.b1_addr;
    w_data   = m_rd_bank ? bus.b0_wdata : bus.b1_wdata;
    rd_exp   = m_valid_d ? m_rd_word : 3'd0;
    n_checks++; if ({bus.b0_wren, bus.b1_wren} !== wren_exp) begin n_errors++; $display("FAIL %s_wren got %b want %b", tag, {bus.b0_wren, bus.b1_wren}, wren_exp); end
    if (m_wr_pend) begin
      n_checks++; if (w_addr !== ADDR_W'(m_wr_addr) || w_data !== m_wr_data) begin n_errors++; $display("FAIL %s_waddr got %0d/%0d want %0d/%0d", tag, w_addr, w_data, m_wr_addr, m_wr_data); end
    end
    n_checks++; if (bus.rd_data !== rd_exp) begin n_errors++; $display("FAIL %s_rd_data got %0d want %0d", tag, bus.rd_data, rd_exp); end
    n_checks++; if (bus.wr_ready !== m_filling) begin n_errors++; $display("FAIL %s_wr_ready got %b want %b", tag, bus.wr_ready, m_filling); end
    n_checks++; if (bus.rd_bank !== m_rd_bank || bus.frame_valid !== m_valid) begin n_errors++; $display("FAIL %s_bank got %b/%b want %b/%b", tag, bus.rd_bank, bus.frame_valid, m_rd_bank, m_valid); end
    cycle();
  endtask

  task automatic test_abort();
    int drops0;
    drive(1, 0, 0); observe_cycle("abort_sof");
    for (int c = 0; c < 20000 && m_count < 1234; c++) begin
      drive(0, $urandom_range(0, 3) != 0, 1'($urandom)); observe_cycle("abort_fill");
    end
    n_checks++; if (m_count != 1234) begin n_errors++; $display("FAIL abort_budget got %0d accepts want 1234", m_count); end
    drops0 = exp_drop();
    drive(1, 1, 0); observe_cycle("abort_pulse");
    drive(0, 1, 0);
    @(negedge vclk);
    n_checks++; if (bus.drop_cnt !== 8'(exp_drop()) || exp_drop() == drops0 && exp_drop() != 0) begin n_errors++; $display("FAIL abort_drop got %0d want %0d", bus.drop_cnt, exp_drop()); end
    n_checks++; if ({bus.b0_wren, bus.b1_wren} !== 2'b00) begin n_errors++; $display("FAIL abort_discard got wren=%b want 00", {bus.b0_wren, bus.b1_wren}); end
    cycle();
    drive(0, 0, 0);
    @(negedge vclk);
    n_checks++; if (bus.b1_wren !== 1'b1 || bus.b1_addr !== '0) begin n_errors++; $display("FAIL abort_restart got wren=%b addr=%0d want 1/0", bus.b1_wren, bus.b1_addr); end
    cycle();
  endtask

  task automatic fill_frame(input string tag);
    for (int c = 0; c < 60000 && !m_full; c++) begin
      drive(0, 1, 1'($urandom)); observe_cycle(tag);
    end
    n_checks++; if (!m_full) begin n_errors++; $display("FAIL %s_budget got %0d words want %0d", tag, m_count, FRAME_WORDS); end
    drive(0, 0, 0); observe_cycle(tag);
  endtask

  task automatic test_done_drops();
    for (int c = 0; c < 1000; c++) begin
      drive(c == 100 || c == 200 || c == 300, 1'($urandom), 0); observe_cycle("done_wait");
    end
    n_checks++; if (bus.drop_cnt !== 8'(exp_drop())) begin n_errors++; $display("FAIL done_drop got %0d want %0d", bus.drop_cnt, exp_drop()); end
    n_checks++; if (bus.rd_bank !== 1'b0) begin n_errors++; $display("FAIL done_no_swap got %b want 0", bus.rd_bank); end
  endtask

  task automatic test_swap();
    drive(0, 0, 1); observe_cycle("swap_edge");
    @(negedge vclk);
    n_checks++; if (bus.rd_bank !== 1'b1 || bus.frame_valid !== 1'b1) begin n_errors++; $display("FAIL swap_bank got %b/%b want 1/1", bus.rd_bank, bus.frame_valid); end
    for (int c = 0; c < 20; c++) begin
      drive(0, 1'($urandom), 1'($urandom)); observe_cycle("swap_idle");
    end
  endtask

  task automatic test_readback();
    for (int c = 0; c < 300; c++) begin
      drive(0, 0, 1'($urandom));
      bus.rd_en = (c < 2) || ($urandom_range(0, 3) != 0);
      if (c == 0) bus.rd_addr = 16'd5;
      #1;
      n_checks++; if (bus.b1_addr !== bus.rd_addr || bus.b1_rden !== bus.rd_en || bus.b0_rden !== 1'b0) begin n_errors++; $display("FAIL read_route got addr=%0d rden=%b%b want %0d/%b0", bus.b1_addr, bus.b1_rden, bus.b0_rden, bus.rd_addr, bus.rd_en); end
      observe_cycle("readback");
    end
  endtask

  task automatic test_swap_sof();
    int drops0;
    drive(1, 0, 0); observe_cycle("frame2_sof");
    fill_frame("frame2");
    repeat (5) begin drive(0, 0, 0); observe_cycle("frame2_done"); end
    drops0 = exp_drop();
    drive(1, 0, 1); observe_cycle("swap_sof");
    drive(0, 1, 0);
    @(negedge vclk);
    n_checks++; if (bus.rd_bank !== 1'b0 || bus.wr_ready !== 1'b1) begin n_errors++; $display("FAIL swap_sof_state got bank=%b ready=%b want 0/1", bus.rd_bank, bus.wr_ready); end
    n_checks++; if (bus.drop_cnt !== 8'(drops0)) begin n_errors++; $display("FAIL swap_sof_drop got %0d want %0d", bus.drop_cnt, drops0); end
    cycle();
    drive(0, 0, 0);
    @(negedge vclk);
    n_checks++; if (bus.b1_wren !== 1'b1 || bus.b1_addr !== '0 || bus.b0_wren !== 1'b0) begin n_errors++; $display("FAIL swap_sof_write got wren=%b%b addr=%0d want 01/0", bus.b0_wren, bus.b1_wren, bus.b1_addr); end
    cycle();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      drive(1, 1'($urandom), 0); observe_cycle("sat_pulse");
      drive(0, 1, 0);            observe_cycle("sat_fill");
    end
    n_checks++; if (bus.drop_cnt !== 8'(exp_drop())) begin n_errors++; $display("FAIL saturate_drop got %0d want %0d", bus.drop_cnt, exp_drop()); end
  endtask

  task automatic test_reset_mid_fill();
    apply_reset();
    drive(0, 1, 0);
    @(negedge vclk);
    n_checks++; if ({bus.wr_ready, bus.rd_bank, bus.frame_valid} !== 3'b000 || bus.drop_cnt !== 8'd0) begin n_errors++; $display("FAIL midreset_state got %b drop=%0d want 000/0", {bus.wr_ready, bus.rd_bank, bus.frame_valid}, bus.drop_cnt); end
    cycle();
    drive(1, 0, 0); observe_cycle("midreset_sof");
    drive(0, 1, 0); observe_cycle("midreset_fill");
    drive(0, 0, 0);
    @(negedge vclk);
    n_checks++; if (bus.b1_wren !== 1'b1 || bus.b1_addr !== '0) begin n_errors++; $display("FAIL midreset_write got wren=%b addr=%0d want 1/0", bus.b1_wren, bus.b1_addr); end
    cycle();
  endtask

  initial begin
    test_reset();
    test_abort();
    fill_frame("frame1");
    test_done_drops();
    test_swap();
    test_readback();
    test_swap_sof();
    test_saturate();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
